// File: rtl/sr_pulse_driver_if.sv
// rtl/sr_pulse_driver_if.sv - button inputs and S/R/busy outputs of the SR pulse driver.
// q_est is present only when SR_PULSE_DRIVER_STATUS_EN is defined.
interface sr_pulse_driver_if;
    logic btn_set;
    logic btn_rst;
    logic S;
    logic R;
    logic busy;
`ifdef SR_PULSE_DRIVER_STATUS_EN
    logic q_est;

    modport master (
        output btn_set,
        output btn_rst,
        input  S,
        input  R,
        input  busy,
        input  q_est
    );

    modport slave (
        input  btn_set,
        input  btn_rst,
        output S,
        output R,
        output busy,
        output q_est
    );
`else
    modport master (
        output btn_set,
        output btn_rst,
        input  S,
        input  R,
        input  busy
    );

    modport slave (
        input  btn_set,
        input  btn_rst,
        output S,
        output R,
        output busy
    );
`endif
endinterface

// File: rtl/sr_pulse_driver.sv
// rtl/sr_pulse_driver.sv - debounced push-buttons to mutually exclusive S/R pulses for a NOR latch.
// Optional macro SR_PULSE_DRIVER_STATUS_EN adds q_est, the expected downstream latch state.
module sr_pulse_driver #(
    parameter int unsigned DEB_CNT   = 1000000,
    parameter int unsigned PULSE_LEN = 4
) (
    input  logic              clk,
    input  logic              rst,
    sr_pulse_driver_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, PULSE_S, PULSE_R, GAP} state_t;

    localparam logic [23:0] DEB_MAX = 24'(DEB_CNT - 1);
    localparam logic [7:0]  PL_MAX  = 8'(PULSE_LEN - 1);

    // Index 0 is the set button, index 1 the reset button.
    logic [1:0]  sync1_q;
    logic [1:0]  sync2_q;
    logic [1:0]  deb_q;
    logic [1:0]  rise_q;
    logic [23:0] cnt_q [2];

    state_t      state_q;
    logic [7:0]  pcnt_q;
    logic        s_q;
    logic        r_q;
    logic        pend_s_q;
    logic        pend_r_q;
`ifdef SR_PULSE_DRIVER_STATUS_EN
    logic        q_est_q;
`endif

    logic        can_start_d;
    logic        start_r_d;
    logic        start_s_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            deb_q   <= '0;
            rise_q  <= '0;
            for (int i = 0; i < 2; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q <= {bus.btn_rst, bus.btn_set};
            sync2_q <= sync1_q;
            for (int i = 0; i < 2; i++) begin
                rise_q[i] <= 1'b0;
                if (sync2_q[i] == deb_q[i]) begin
                    cnt_q[i] <= '0;
                end else if (cnt_q[i] == DEB_MAX) begin
                    deb_q[i]  <= sync2_q[i];
                    cnt_q[i]  <= '0;
                    rise_q[i] <= sync2_q[i];
                end else begin
                    cnt_q[i] <= cnt_q[i] + 24'd1;
                end
            end
        end
    end

    // GAP arbitrates like IDLE so consecutive pulses are separated by a single low cycle.
    assign can_start_d = (state_q == IDLE) || (state_q == GAP);
    assign start_r_d   = can_start_d && pend_r_q;
    assign start_s_d   = can_start_d && pend_s_q && !pend_r_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            pcnt_q   <= '0;
            s_q      <= 1'b0;
            r_q      <= 1'b0;
            pend_s_q <= 1'b0;
            pend_r_q <= 1'b0;
`ifdef SR_PULSE_DRIVER_STATUS_EN
            q_est_q  <= 1'b0;
`endif
        end else begin
            pend_r_q <= rise_q[1] | (pend_r_q & ~start_r_d);
            pend_s_q <= rise_q[0] | (pend_s_q & ~start_s_d);
            case (state_q)
                IDLE, GAP: begin
                    s_q    <= 1'b0;
                    r_q    <= 1'b0;
                    pcnt_q <= '0;
                    if (start_r_d) begin
                        state_q <= PULSE_R;
                        r_q     <= 1'b1;
                    end else if (start_s_d) begin
                        state_q <= PULSE_S;
                        s_q     <= 1'b1;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                PULSE_S: begin
                    if (pcnt_q == PL_MAX) begin
                        s_q     <= 1'b0;
                        state_q <= GAP;
`ifdef SR_PULSE_DRIVER_STATUS_EN
                        q_est_q <= 1'b1;
`endif
                    end else begin
                        pcnt_q <= pcnt_q + 8'd1;
                    end
                end
                PULSE_R: begin
                    if (pcnt_q == PL_MAX) begin
                        r_q     <= 1'b0;
                        state_q <= GAP;
`ifdef SR_PULSE_DRIVER_STATUS_EN
                        q_est_q <= 1'b0;
`endif
                    end else begin
                        pcnt_q <= pcnt_q + 8'd1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    s_q     <= 1'b0;
                    r_q     <= 1'b0;
                end
            endcase
        end
    end

    assign bus.S    = s_q;
    assign bus.R    = r_q;
    assign bus.busy = (state_q != IDLE) || pend_s_q || pend_r_q;
`ifdef SR_PULSE_DRIVER_STATUS_EN
    assign bus.q_est = q_est_q;
`endif

endmodule

// File: tb/tb_sr_pulse_driver.sv
// tb/tb_sr_pulse_driver.sv - directed self-checking bench for sr_pulse_driver (DEB_CNT=8, PULSE_LEN=4).
module tb_sr_pulse_driver;

    localparam int DEB = 8;
    localparam int PL  = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sr_pulse_driver_if bus ();

    sr_pulse_driver #(.DEB_CNT(DEB), .PULSE_LEN(PL)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    logic s_hist [0:99];
    logic r_hist [0:99];
    logic b_hist [0:99];
    logic q_hist [0:99];

    int s_first, s_cnt, s_last, r_first, r_cnt, r_last, both_cnt, b_cnt;

    // Cycle k holds outputs sampled just after the k-th rising edge following the stimulus point.
    task automatic observe(input int from, input int to);
        for (int k = from; k <= to; k++) begin
            @(posedge clk);
            #2;
            s_hist[k] = bus.S;
            r_hist[k] = bus.R;
            b_hist[k] = bus.busy;
`ifdef SR_PULSE_DRIVER_STATUS_EN
            q_hist[k] = bus.q_est;
`else
            q_hist[k] = 1'b0;
`endif
        end
    endtask

    task automatic stats(input int to);
        s_first = -1; s_cnt = 0; s_last = -1;
        r_first = -1; r_cnt = 0; r_last = -1;
        both_cnt = 0; b_cnt = 0;
        for (int k = 1; k <= to; k++) begin
            if (s_hist[k] === 1'b1) begin
                if (s_first < 0) s_first = k;
                s_cnt++;
                s_last = k;
            end
            if (r_hist[k] === 1'b1) begin
                if (r_first < 0) r_first = k;
                r_cnt++;
                r_last = k;
            end
            if (s_hist[k] === 1'b1 && r_hist[k] === 1'b1) both_cnt++;
            if (b_hist[k] === 1'b1) b_cnt++;
        end
    endtask

    task automatic start_point();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bus.btn_set = 1'b0;
        bus.btn_rst = 1'b1;
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            bus.btn_set = ~bus.btn_set;
            bus.btn_rst = ~bus.btn_rst;
            @(posedge clk);
            #2;
            checks++;
            if (bus.S !== 1'b0) begin failures++; $display("FAIL reset_S cyc=%0d got=%b exp=0", k, bus.S); end
            checks++;
            if (bus.R !== 1'b0) begin failures++; $display("FAIL reset_R cyc=%0d got=%b exp=0", k, bus.R); end
            checks++;
            if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy cyc=%0d got=%b exp=0", k, bus.busy); end
        end
        bus.btn_set = 1'b0;
        bus.btn_rst = 1'b0;
        start_point();
        rst = 1'b0;
        observe(1, 20);
        stats(20);
        checks++;
        if (s_cnt + r_cnt + b_cnt !== 0) begin failures++; $display("FAIL reset_quiet got=%0d exp=0", s_cnt + r_cnt + b_cnt); end
    endtask

    task automatic test_single_set();
        start_point();
        bus.btn_set = 1'b1;
        observe(1, 30);
        bus.btn_set = 1'b0;
        observe(31, 45);
        stats(45);
        checks++;
        if (s_first !== 12) begin failures++; $display("FAIL single_s_first got=%0d exp=12", s_first); end
        checks++;
        if (s_cnt !== 4) begin failures++; $display("FAIL single_s_cnt got=%0d exp=4", s_cnt); end
        checks++;
        if (s_last !== 15) begin failures++; $display("FAIL single_s_last got=%0d exp=15", s_last); end
        checks++;
        if (r_cnt !== 0) begin failures++; $display("FAIL single_r_cnt got=%0d exp=0", r_cnt); end
        checks++;
        if (b_hist[10] !== 1'b0) begin failures++; $display("FAIL single_busy10 got=%b exp=0", b_hist[10]); end
        checks++;
        if (b_hist[11] !== 1'b1) begin failures++; $display("FAIL single_busy11 got=%b exp=1", b_hist[11]); end
        checks++;
        if (b_hist[16] !== 1'b1) begin failures++; $display("FAIL single_busy16 got=%b exp=1", b_hist[16]); end
        checks++;
        if (b_hist[17] !== 1'b0) begin failures++; $display("FAIL single_busy17 got=%b exp=0", b_hist[17]); end
`ifdef SR_PULSE_DRIVER_STATUS_EN
        checks++;
        if (q_hist[15] !== 1'b0) begin failures++; $display("FAIL status_set_q15 got=%b exp=0", q_hist[15]); end
        checks++;
        if (q_hist[16] !== 1'b1) begin failures++; $display("FAIL status_set_q16 got=%b exp=1", q_hist[16]); end
`endif
    endtask

    task automatic test_bounce();
        start_point();
        bus.btn_set = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            observe(k, k);
            if (k % 3 == 0) bus.btn_set = ~bus.btn_set;
        end
        bus.btn_set = 1'b0;
        observe(41, 60);
        stats(60);
        checks++;
        if (s_cnt !== 0) begin failures++; $display("FAIL bounce_s_cnt got=%0d exp=0", s_cnt); end
        checks++;
        if (r_cnt !== 0) begin failures++; $display("FAIL bounce_r_cnt got=%0d exp=0", r_cnt); end
        checks++;
        if (b_cnt !== 0) begin failures++; $display("FAIL bounce_busy got=%0d exp=0", b_cnt); end
    endtask

    task automatic test_simultaneous();
        start_point();
        bus.btn_set = 1'b1;
        bus.btn_rst = 1'b1;
        observe(1, 30);
        bus.btn_set = 1'b0;
        bus.btn_rst = 1'b0;
        observe(31, 45);
        stats(45);
        checks++;
        if (r_first !== 12) begin failures++; $display("FAIL simul_r_first got=%0d exp=12", r_first); end
        checks++;
        if (r_cnt !== 4) begin failures++; $display("FAIL simul_r_cnt got=%0d exp=4", r_cnt); end
        checks++;
        if (s_first !== 17) begin failures++; $display("FAIL simul_s_first got=%0d exp=17", s_first); end
        checks++;
        if (s_cnt !== 4 || s_last !== 20) begin failures++; $display("FAIL simul_s_span got=%0d/%0d exp=4/20", s_cnt, s_last); end
        checks++;
        if (both_cnt !== 0) begin failures++; $display("FAIL simul_overlap got=%0d exp=0", both_cnt); end
    endtask

    task automatic test_back_to_back();
        start_point();
        bus.btn_set = 1'b1;
        observe(1, 1);
        bus.btn_rst = 1'b1;
        observe(2, 30);
        bus.btn_set = 1'b0;
        bus.btn_rst = 1'b0;
        observe(31, 45);
        stats(45);
        checks++;
        if (s_first !== 12 || s_cnt !== 4) begin failures++; $display("FAIL b2b_s got=%0d/%0d exp=12/4", s_first, s_cnt); end
        checks++;
        if (r_first !== 17 || r_cnt !== 4) begin failures++; $display("FAIL b2b_r got=%0d/%0d exp=17/4", r_first, r_cnt); end
        checks++;
        if (both_cnt !== 0) begin failures++; $display("FAIL b2b_overlap got=%0d exp=0", both_cnt); end
        checks++;
        if (b_hist[16] !== 1'b1 || b_hist[22] !== 1'b0) begin
            failures++; $display("FAIL b2b_busy got=%b/%b exp=1/0", b_hist[16], b_hist[22]);
        end
`ifdef SR_PULSE_DRIVER_STATUS_EN
        checks++;
        if (q_hist[20] !== 1'b1 || q_hist[21] !== 1'b0) begin
            failures++; $display("FAIL status_rst_q got=%b/%b exp=1/0", q_hist[20], q_hist[21]);
        end
`endif
    endtask

    task automatic test_reset_mid_pulse();
        start_point();
        bus.btn_set = 1'b1;
        observe(1, 13);
        stats(13);
        checks++;
        if (s_first !== 12 || s_cnt !== 2) begin failures++; $display("FAIL midrst_pre got=%0d/%0d exp=12/2", s_first, s_cnt); end
        bus.btn_set = 1'b0;
        rst = 1'b1;
        #1;
        checks++;
        if (bus.S !== 1'b0) begin failures++; $display("FAIL midrst_S_async got=%b exp=0", bus.S); end
        checks++;
        if (bus.busy !== 1'b0) begin failures++; $display("FAIL midrst_busy got=%b exp=0", bus.busy); end
        start_point();
        rst = 1'b0;
        observe(1, 50);
        stats(50);
        checks++;
        if (s_cnt !== 0 || r_cnt !== 0) begin failures++; $display("FAIL midrst_after got=%0d/%0d exp=0/0", s_cnt, r_cnt); end
    endtask

    task automatic test_held_through_reset();
        start_point();
        bus.btn_set = 1'b1;
        observe(1, 20);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        observe(1, 30);
        bus.btn_set = 1'b0;
        observe(31, 45);
        stats(45);
        checks++;
        if (s_first !== 12 || s_cnt !== 4) begin failures++; $display("FAIL held_rst_s got=%0d/%0d exp=12/4", s_first, s_cnt); end
        checks++;
        if (r_cnt !== 0) begin failures++; $display("FAIL held_rst_r got=%0d exp=0", r_cnt); end
    endtask

    initial begin
        bus.btn_set = 1'b0;
        bus.btn_rst = 1'b0;
        test_reset();
        test_single_set();
        test_bounce();
        test_simultaneous();
        test_back_to_back();
        test_reset_mid_pulse();
        test_held_through_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
